// File: rtl/nexus_micro_pifo_sorter.sv
// nexus_micro_pifo_sorter
//
// Sort-and-shift register for the micro-level PIFO stage. Holds up to ENTRIES
// {metadata, priority} words in ascending priority order (lower value = served
// first). Equal priorities stay in arrival order. Push and pop may fire in the
// same cycle. With EVICT=1 a push into a full queue is accepted and the worst
// word (old tail or the new word itself) is reported on the drop port.
//
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset
//   i_flush           synchronous clear of all entries (no drop report)
//   i_push_valid      push request
//   o_push_ready      push accepted this cycle (depends on i_pop_ready)
//   i_push_data       {metadata[MTW-1:0], priority[PTW-1:0]}
//   o_pop_valid       head entry valid
//   i_pop_ready       consumer takes the head this cycle
//   o_pop_data        head entry (entry[0])
//   o_drop_valid      registered one-cycle pulse: a word was discarded
//   o_drop_data       the discarded word
//   o_count           number of valid entries
//   o_full, o_empty   occupancy flags
module nexus_micro_pifo_sorter #(
    parameter int PTW     = 16,
    parameter int MTW     = 32,
    parameter int ENTRIES = 16,
    parameter int EVICT   = 0,
    localparam int CW     = $clog2(ENTRIES + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_push_valid,
    output logic               o_push_ready,
    input  logic [MTW+PTW-1:0] i_push_data,
    output logic               o_pop_valid,
    input  logic               i_pop_ready,
    output logic [MTW+PTW-1:0] o_pop_data,
    output logic               o_drop_valid,
    output logic [MTW+PTW-1:0] o_drop_data,
    output logic [CW-1:0]      o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam int W = MTW + PTW;
    localparam logic [W-1:0] ONES = '1;

    logic [W-1:0]   entry      [ENTRIES];
    logic [CW-1:0]  count;
    logic           drop_valid;
    logic [W-1:0]   drop_data;

    logic [W-1:0]   base       [ENTRIES];
    logic [W-1:0]   nxt_entry  [ENTRIES];
    logic [CW-1:0]  base_count;
    logic [CW-1:0]  idx;
    logic [CW-1:0]  nxt_count;
    logic [PTW-1:0] new_prio;
    logic           full;
    logic           pop_fire;
    logic           push_fire;
    logic           evict_full;
    logic           discard_new;
    logic [W-1:0]   drop_word;

    assign full      = (count == CW'(ENTRIES));
    assign pop_fire  = (count != '0) & i_pop_ready;
    assign new_prio  = i_push_data[PTW-1:0];

    assign o_push_ready = !i_rst & !i_flush & (!full | pop_fire | (EVICT != 0));
    assign push_fire    = i_push_valid & o_push_ready;

    assign o_pop_valid  = (count != '0);
    assign o_pop_data   = entry[0];
    assign o_count      = count;
    assign o_full       = full;
    assign o_empty      = (count == '0);
    assign o_drop_valid = drop_valid;
    assign o_drop_data  = drop_data;

    // Insertion happens into the queue as it looks after any pop, so the new
    // word can never overtake the head leaving in the same cycle.
    always_comb begin
        for (int k = 0; k < ENTRIES - 1; k++) begin
            base[k] = pop_fire ? entry[k+1] : entry[k];
        end
        base[ENTRIES-1] = pop_fire ? ONES : entry[ENTRIES-1];
        base_count = pop_fire ? (count - CW'(1)) : count;

        // First valid slot with a strictly larger priority; ties land behind
        // existing equal-priority words. Scanning downward lets the lowest
        // matching index win.
        idx = base_count;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if ((CW'(k) < base_count) && (new_prio < base[k][PTW-1:0])) begin
                idx = CW'(k);
            end
        end

        // Only reachable with EVICT=1: full, push accepted, nothing leaving.
        evict_full  = full & push_fire & !pop_fire & (EVICT != 0);
        discard_new = evict_full & (idx == CW'(ENTRIES));
        drop_word   = discard_new ? i_push_data : entry[ENTRIES-1];

        for (int k = 0; k < ENTRIES; k++) begin
            nxt_entry[k] = base[k];
        end
        if (push_fire && !discard_new) begin
            nxt_entry[0] = (idx == '0) ? i_push_data : base[0];
            for (int k = 1; k < ENTRIES; k++) begin
                if (CW'(k) < idx) begin
                    nxt_entry[k] = base[k];
                end else if (CW'(k) == idx) begin
                    nxt_entry[k] = i_push_data;
                end else begin
                    nxt_entry[k] = base[k-1];
                end
            end
        end

        nxt_count = count;
        if (push_fire && !pop_fire && !full) begin
            nxt_count = count + CW'(1);
        end else if (pop_fire && !push_fire) begin
            nxt_count = count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count      <= '0;
            drop_valid <= 1'b0;
            drop_data  <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                entry[k] <= ONES;
            end
        end else if (i_flush) begin
            count      <= '0;
            drop_valid <= 1'b0;
            for (int k = 0; k < ENTRIES; k++) begin
                entry[k] <= ONES;
            end
        end else begin
            count      <= nxt_count;
            drop_valid <= evict_full;
            if (evict_full) begin
                drop_data <= drop_word;
            end
            for (int k = 0; k < ENTRIES; k++) begin
                entry[k] <= nxt_entry[k];
            end
        end
    end

endmodule

// File: tb/tb_nexus_micro_pifo_sorter.sv
// Testbench for nexus_micro_pifo_sorter. Four instances share one stimulus:
//   a: ENTRIES=16 EVICT=0    b: ENTRIES=16 EVICT=1
//   c: ENTRIES=4  EVICT=1    d: ENTRIES=64 EVICT=0
// Directed scenarios check a/b; the random scenario checks all four against a
// stable-sorted reference queue each.
module tb_nexus_micro_pifo_sorter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic [47:0] push_data;
    logic        pop_ready;

    logic        a_push_ready, a_pop_valid, a_drop_valid, a_full, a_empty;
    logic [47:0] a_pop_data, a_drop_data;
    logic [4:0]  a_count;
    logic        b_push_ready, b_pop_valid, b_drop_valid, b_full, b_empty;
    logic [47:0] b_pop_data, b_drop_data;
    logic [4:0]  b_count;
    logic        c_push_ready, c_pop_valid, c_drop_valid, c_full, c_empty;
    logic [47:0] c_pop_data, c_drop_data;
    logic [2:0]  c_count;
    logic        d_push_ready, d_pop_valid, d_drop_valid, d_full, d_empty;
    logic [47:0] d_pop_data, d_drop_data;
    logic [6:0]  d_count;

    int checks = 0;
    int errors = 0;

    logic [47:0] mdl [4][66];
    int          mcnt [4];
    int          mdep [4];
    bit          mev  [4];
    bit          edv  [4];
    logic [47:0] edd  [4];

    always #5 clk = ~clk;

    nexus_micro_pifo_sorter #(.PTW(16), .MTW(32), .ENTRIES(16), .EVICT(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push_valid(push_valid),
        .o_push_ready(a_push_ready), .i_push_data(push_data), .o_pop_valid(a_pop_valid),
        .i_pop_ready(pop_ready), .o_pop_data(a_pop_data), .o_drop_valid(a_drop_valid),
        .o_drop_data(a_drop_data), .o_count(a_count), .o_full(a_full), .o_empty(a_empty));

    nexus_micro_pifo_sorter #(.PTW(16), .MTW(32), .ENTRIES(16), .EVICT(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push_valid(push_valid),
        .o_push_ready(b_push_ready), .i_push_data(push_data), .o_pop_valid(b_pop_valid),
        .i_pop_ready(pop_ready), .o_pop_data(b_pop_data), .o_drop_valid(b_drop_valid),
        .o_drop_data(b_drop_data), .o_count(b_count), .o_full(b_full), .o_empty(b_empty));

    nexus_micro_pifo_sorter #(.PTW(16), .MTW(32), .ENTRIES(4), .EVICT(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push_valid(push_valid),
        .o_push_ready(c_push_ready), .i_push_data(push_data), .o_pop_valid(c_pop_valid),
        .i_pop_ready(pop_ready), .o_pop_data(c_pop_data), .o_drop_valid(c_drop_valid),
        .o_drop_data(c_drop_data), .o_count(c_count), .o_full(c_full), .o_empty(c_empty));

    nexus_micro_pifo_sorter #(.PTW(16), .MTW(32), .ENTRIES(64), .EVICT(0)) u_d (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push_valid(push_valid),
        .o_push_ready(d_push_ready), .i_push_data(push_data), .o_pop_valid(d_pop_valid),
        .i_pop_ready(pop_ready), .o_pop_data(d_pop_data), .o_drop_valid(d_drop_valid),
        .o_drop_data(d_drop_data), .o_count(d_count), .o_full(d_full), .o_empty(d_empty));

    function automatic logic [47:0] mk(input logic [31:0] meta, input logic [15:0] prio);
        return {meta, prio};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
        tick(); tick();
        checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_count); end
        checks++; if (a_pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b want 0", a_pop_valid); end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", a_full); end
        checks++; if (a_drop_valid !== 1'b0) begin errors++; $display("FAIL reset_drop_valid: got %b want 0", a_drop_valid); end
        checks++; if (b_drop_data !== 48'h0) begin errors++; $display("FAIL reset_drop_data: got %h want 0", b_drop_data); end
        checks++; if (a_push_ready !== 1'b0) begin errors++; $display("FAIL reset_push_ready: got %b want 0", a_push_ready); end
        checks++; if (a_pop_data !== {48{1'b1}}) begin errors++; $display("FAIL reset_head_ones: got %h want all-ones", a_pop_data); end
        rst = 1'b0;
        #1;
        checks++; if (a_push_ready !== 1'b1) begin errors++; $display("FAIL release_push_ready: got %b want 1", a_push_ready); end
    endtask

    task automatic test_sort();
        logic [47:0] ins [4];
        logic [47:0] exp [4];
        ins = '{mk(32'hA, 16'd5), mk(32'hB, 16'd2), mk(32'hC, 16'd9), mk(32'hD, 16'd2)};
        exp = '{mk(32'hB, 16'd2), mk(32'hD, 16'd2), mk(32'hA, 16'd5), mk(32'hC, 16'd9)};
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_data = ins[i];
            tick();
        end
        push_valid = 1'b0;
        checks++; if (a_count !== 5'd4) begin errors++; $display("FAIL sort_count: got %0d want 4", a_count); end
        pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_pop_valid !== 1'b1 || a_pop_data !== exp[i]) begin
                errors++; $display("FAIL sort_pop%0d: got v=%b %h want v=1 %h", i, a_pop_valid, a_pop_data, exp[i]);
            end
            tick();
        end
        pop_ready = 1'b0;
        checks++; if (a_empty !== 1'b1 || a_pop_valid !== 1'b0) begin
            errors++; $display("FAIL sort_drained: got empty=%b pop_valid=%b want 1 0", a_empty, a_pop_valid);
        end
    endtask

    task automatic test_full_pop_push();
        logic [47:0] exp [$];
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1; push_data = mk(32'h100 + 32'(i), 16'(i));
            tick();
        end
        push_valid = 1'b1; push_data = mk(32'h333, 16'd3); pop_ready = 1'b0;
        #1;
        checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", a_full); end
        checks++; if (a_push_ready !== 1'b0) begin errors++; $display("FAIL full_backpressure: got %b want 0", a_push_ready); end
        pop_ready = 1'b1;
        #1;
        checks++; if (a_push_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b want 1", a_push_ready); end
        checks++; if (a_pop_data !== mk(32'h100, 16'd0)) begin errors++; $display("FAIL full_pop_head: got %h want %h", a_pop_data, mk(32'h100, 16'd0)); end
        tick();
        push_valid = 1'b0; pop_ready = 1'b0;
        checks++; if (a_count !== 5'd16) begin errors++; $display("FAIL full_swap_count: got %0d want 16", a_count); end
        for (int p = 1; p < 16; p++) begin
            exp.push_back(mk(32'h100 + 32'(p), 16'(p)));
            if (p == 3) exp.push_back(mk(32'h333, 16'd3));
        end
        pop_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (a_pop_data !== exp[i]) begin errors++; $display("FAIL full_drain%0d: got %h want %h", i, a_pop_data, exp[i]); end
            tick();
        end
        pop_ready = 1'b0;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", a_empty); end
    endtask

    task automatic test_single_swap();
        push_valid = 1'b1; push_data = mk(32'h77, 16'd7);
        tick();
        push_valid = 1'b1; push_data = mk(32'h11, 16'd1); pop_ready = 1'b1;
        #1;
        checks++; if (a_push_ready !== 1'b1) begin errors++; $display("FAIL swap1_ready: got %b want 1", a_push_ready); end
        checks++; if (a_pop_data !== mk(32'h77, 16'd7) || a_count !== 5'd1) begin
            errors++; $display("FAIL swap1_pop: got %h cnt=%0d want %h cnt=1", a_pop_data, a_count, mk(32'h77, 16'd7));
        end
        tick();
        push_valid = 1'b0; pop_ready = 1'b0;
        checks++; if (a_pop_data !== mk(32'h11, 16'd1) || a_count !== 5'd1) begin
            errors++; $display("FAIL swap1_head: got %h cnt=%0d want %h cnt=1", a_pop_data, a_count, mk(32'h11, 16'd1));
        end
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL swap1_empty: got %b want 1", a_empty); end
    endtask

    task automatic test_evict();
        logic [47:0] exp [$];
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1; push_data = mk(32'h100 + 32'(i), 16'(i));
            tick();
        end
        push_valid = 1'b1; push_data = mk(32'h444, 16'd4);
        #1;
        checks++; if (b_push_ready !== 1'b1) begin errors++; $display("FAIL evict_ready: got %b want 1", b_push_ready); end
        tick();
        push_valid = 1'b0;
        checks++; if (b_drop_valid !== 1'b1 || b_drop_data !== mk(32'h10F, 16'd15)) begin
            errors++; $display("FAIL evict_tail: got v=%b %h want v=1 %h", b_drop_valid, b_drop_data, mk(32'h10F, 16'd15));
        end
        checks++; if (b_count !== 5'd16) begin errors++; $display("FAIL evict_count: got %0d want 16", b_count); end
        checks++; if (a_drop_valid !== 1'b0) begin errors++; $display("FAIL noevict_drop: got %b want 0", a_drop_valid); end
        tick();
        checks++; if (b_drop_valid !== 1'b0) begin errors++; $display("FAIL evict_pulse_len: got %b want 0", b_drop_valid); end
        push_valid = 1'b1; push_data = mk(32'h555, 16'd20);
        tick();
        push_valid = 1'b0;
        checks++; if (b_drop_valid !== 1'b1 || b_drop_data !== mk(32'h555, 16'd20)) begin
            errors++; $display("FAIL evict_self: got v=%b %h want v=1 %h", b_drop_valid, b_drop_data, mk(32'h555, 16'd20));
        end
        tick();
        checks++; if (b_drop_valid !== 1'b0) begin errors++; $display("FAIL evict_self_pulse: got %b want 0", b_drop_valid); end
        for (int p = 0; p < 15; p++) begin
            exp.push_back(mk(32'h100 + 32'(p), 16'(p)));
            if (p == 4) exp.push_back(mk(32'h444, 16'd4));
        end
        pop_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (b_pop_data !== exp[i]) begin errors++; $display("FAIL evict_drain%0d: got %h want %h", i, b_pop_data, exp[i]); end
            tick();
        end
        pop_ready = 1'b0;
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL evict_drained: got %b want 1", b_empty); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) begin
            push_valid = 1'b1; push_data = mk(32'h200 + 32'(i), 16'(i));
            tick();
        end
        push_valid = 1'b0;
        checks++; if (a_count !== 5'd8) begin errors++; $display("FAIL flush_pre_count: got %0d want 8", a_count); end
        flush = 1'b1; push_valid = 1'b1; push_data = mk(32'h999, 16'd1); pop_ready = 1'b1;
        #1;
        checks++; if (a_push_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", a_push_ready); end
        tick();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        checks++; if (a_count !== 5'd0 || a_pop_valid !== 1'b0 || b_count !== 5'd0) begin
            errors++; $display("FAIL flush_count: got a=%0d v=%b b=%0d want 0 0 0", a_count, a_pop_valid, b_count);
        end
        checks++; if (a_drop_valid !== 1'b0 || b_drop_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop: got a=%b b=%b want 0 0", a_drop_valid, b_drop_valid);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_data = mk(32'h300 + 32'(i), 16'(9 - i));
            tick();
        end
        push_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (a_count !== 5'd0 || a_drop_valid !== 1'b0 || a_empty !== 1'b1) begin
            errors++; $display("FAIL midreset: got cnt=%0d drop=%b empty=%b want 0 0 1", a_count, a_drop_valid, a_empty);
        end
    endtask

    task automatic test_random();
        int          oc [4];
        logic        opv [4], ordy [4], odv [4];
        logic [47:0] opd [4], odd [4];
        bit          pv, pr, fl, popf, pf, er;
        int          pvp, prp, j;
        logic [47:0] d, t;
        logic [15:0] p;
        mdep = '{16, 16, 4, 64};
        mev  = '{1'b0, 1'b1, 1'b1, 1'b0};
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin mcnt[i] = 0; edv[i] = 1'b0; edd[i] = '0; end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            oc[0] = int'(a_count); opv[0] = a_pop_valid; opd[0] = a_pop_data; odv[0] = a_drop_valid; odd[0] = a_drop_data;
            oc[1] = int'(b_count); opv[1] = b_pop_valid; opd[1] = b_pop_data; odv[1] = b_drop_valid; odd[1] = b_drop_data;
            oc[2] = int'(c_count); opv[2] = c_pop_valid; opd[2] = c_pop_data; odv[2] = c_drop_valid; odd[2] = c_drop_data;
            oc[3] = int'(d_count); opv[3] = d_pop_valid; opd[3] = d_pop_data; odv[3] = d_drop_valid; odd[3] = d_drop_data;
            for (int i = 0; i < 4; i++) begin
                checks++; if (oc[i] != mcnt[i] || opv[i] !== (mcnt[i] > 0)) begin
                    errors++; $display("FAIL rnd_count u%0d cyc%0d: got %0d v=%b want %0d", i, cyc, oc[i], opv[i], mcnt[i]);
                end
                if (mcnt[i] > 0) begin
                    checks++; if (opd[i] !== mdl[i][0]) begin
                        errors++; $display("FAIL rnd_head u%0d cyc%0d: got %h want %h", i, cyc, opd[i], mdl[i][0]);
                    end
                end
                checks++; if (odv[i] !== edv[i] || (edv[i] && odd[i] !== edd[i])) begin
                    errors++; $display("FAIL rnd_drop u%0d cyc%0d: got v=%b %h want v=%b %h", i, cyc, odv[i], odd[i], edv[i], edd[i]);
                end
            end
            if (((cyc / 500) % 2) == 0) begin pvp = 85; prp = 30; end else begin pvp = 30; prp = 80; end
            pv = ($urandom_range(99) < pvp);
            pr = ($urandom_range(99) < prp);
            fl = ($urandom_range(511) == 0);
            p  = ($urandom_range(15) == 0) ? 16'hFFFF : 16'($urandom_range(7));
            d  = mk(32'(cyc), p);
            push_valid = pv; pop_ready = pr; flush = fl; push_data = d;
            #1;
            ordy[0] = a_push_ready; ordy[1] = b_push_ready; ordy[2] = c_push_ready; ordy[3] = d_push_ready;
            for (int i = 0; i < 4; i++) begin
                er = !fl && (mcnt[i] < mdep[i] || (pr && mcnt[i] > 0) || mev[i]);
                checks++; if (ordy[i] !== er) begin
                    errors++; $display("FAIL rnd_ready u%0d cyc%0d: got %b want %b", i, cyc, ordy[i], er);
                end
                popf = (mcnt[i] > 0) && pr;
                pf   = pv && er;
                edv[i] = 1'b0;
                if (fl) begin
                    mcnt[i] = 0;
                end else begin
                    if (popf) begin
                        for (int k = 0; k < mcnt[i] - 1; k++) mdl[i][k] = mdl[i][k+1];
                        mcnt[i]--;
                    end
                    if (pf) begin
                        j = mcnt[i];
                        mdl[i][j] = d;
                        mcnt[i]++;
                        while (j > 0 && d[15:0] < mdl[i][j-1][15:0]) begin
                            t = mdl[i][j-1]; mdl[i][j-1] = d; mdl[i][j] = t; j--;
                        end
                        if (mcnt[i] > mdep[i]) begin
                            edv[i] = 1'b1;
                            edd[i] = mdl[i][mcnt[i]-1];
                            mcnt[i]--;
                        end
                    end
                end
            end
            tick();
        end
        push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sort();
        test_full_pop_push();
        test_single_swap();
        test_evict();
        test_flush();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
